// File: rtl/hack_mem_io.sv
// Data memory and memory-mapped I/O for the Hack CPU: RAM, screen shadow buffer with a
// display-bound write FIFO, and a keyboard register. Reads are combinational.
module hack_mem_io #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned FIFO_AW    = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [14:0]        MAddr,
    input  logic [15:0]        MWrite,
    input  logic               loadM,
    output logic [15:0]        MRead,
    input  logic               kbd_valid,
    input  logic [15:0]        kbd_code,
    output logic               scr_valid,
    output logic [12:0]        scr_addr,
    output logic [15:0]        scr_data,
    input  logic               scr_ready,
    output logic [FIFO_AW:0]   fifo_level,
    output logic               scr_ovf,
    output logic               addr_err
);

    localparam logic [FIFO_AW:0] LevelFull = (FIFO_AW + 1)'(FIFO_DEPTH);

    logic [15:0] ram_q    [16384];
    logic [15:0] shadow_q [8192];
    logic [28:0] fifo_q   [FIFO_DEPTH];

    logic [15:0]        kbd_q;
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   level_q, level_d;
    logic               scr_ovf_q, addr_err_q;

    logic is_ram, is_scr, is_kbd;
    logic ram_we, scr_we, bad_we;
    logic pop, push_ok, drop;

    assign is_ram = ~MAddr[14];
    assign is_scr = (MAddr[14:13] == 2'b10);
    assign is_kbd = (MAddr == 15'h6000);

    // Writes in a reset cycle are ignored, including RAM and shadow updates.
    assign ram_we = loadM & ~rst & is_ram;
    assign scr_we = loadM & ~rst & is_scr;
    assign bad_we = loadM & ~rst & ~is_ram & ~is_scr;

    assign scr_valid = (level_q != '0);
    assign pop       = scr_valid & scr_ready & ~rst;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push_ok   = scr_we & ((level_q != LevelFull) | pop);
    assign drop      = scr_we & ~push_ok;

    always_comb begin
        MRead = 16'h0000;
        if (is_ram) begin
            MRead = ram_q[MAddr[13:0]];
        end else if (is_scr) begin
            MRead = shadow_q[MAddr[12:0]];
        end else if (is_kbd) begin
            MRead = kbd_q;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
        end
        case ({push_ok, pop})
            2'b10:   level_d = level_q + (FIFO_AW + 1)'(1);
            2'b01:   level_d = level_q - (FIFO_AW + 1)'(1);
            default: level_d = level_q;
        endcase
    end

    // Storage arrays carry no reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_q[MAddr[13:0]] <= MWrite;
        end
        if (scr_we) begin
            shadow_q[MAddr[12:0]] <= MWrite;
        end
        if (push_ok) begin
            fifo_q[wr_ptr_q] <= {MAddr[12:0], MWrite};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            kbd_q      <= 16'h0000;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            scr_ovf_q  <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            if (kbd_valid) begin
                kbd_q <= kbd_code;
            end
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            scr_ovf_q  <= scr_ovf_q | drop;
            addr_err_q <= addr_err_q | bad_we;
        end
    end

    assign {scr_addr, scr_data} = fifo_q[rd_ptr_q];
    assign fifo_level           = level_q;
    assign scr_ovf              = scr_ovf_q;
    assign addr_err             = addr_err_q;

endmodule

// File: tb/tb_hack_mem_io.sv
// Bench for hack_mem_io: directed stimulus with a scoreboard queue for display-bound
// screen writes, popped by a monitor whenever the DUT hands off its FIFO head.
module tb_hack_mem_io;

    logic        clk = 1'b0;
    logic        rst;
    logic [14:0] MAddr;
    logic [15:0] MWrite;
    logic        loadM;
    logic [15:0] MRead;
    logic        kbd_valid;
    logic [15:0] kbd_code;
    logic        scr_valid;
    logic [12:0] scr_addr;
    logic [15:0] scr_data;
    logic        scr_ready;
    logic [3:0]  fifo_level;
    logic        scr_ovf;
    logic        addr_err;

    int checks = 0;
    int errors = 0;
    logic [28:0] exp_q [$];

    always #5 clk = ~clk;

    hack_mem_io #(
        .FIFO_DEPTH(8),
        .FIFO_AW   (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .MAddr     (MAddr),
        .MWrite    (MWrite),
        .loadM     (loadM),
        .MRead     (MRead),
        .kbd_valid (kbd_valid),
        .kbd_code  (kbd_code),
        .scr_valid (scr_valid),
        .scr_addr  (scr_addr),
        .scr_data  (scr_data),
        .scr_ready (scr_ready),
        .fifo_level(fifo_level),
        .scr_ovf   (scr_ovf),
        .addr_err  (addr_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Inputs change only just after a rising edge; checks happen on the falling edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [14:0] a, input logic [15:0] d);
        MAddr  = a;
        MWrite = d;
        loadM  = 1'b1;
        cyc();
        loadM  = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [14:0] a, input logic [15:0] exp);
        MAddr = a;
        @(negedge clk);
        chk(name, 32'(MRead), 32'(exp));
        cyc();
    endtask

    task automatic monitor();
        logic [28:0] e;
        forever begin
            @(negedge clk);
            if (!rst && scr_valid && scr_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scr_pop: got %h with empty scoreboard, expected none",
                             {scr_addr, scr_data});
                end else begin
                    e = exp_q.pop_front();
                    chk("scr_head", 32'({scr_addr, scr_data}), 32'(e));
                end
            end
        end
    endtask

    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        fork
            monitor();
        join_none

        rst       = 1'b1;
        MAddr     = '0;
        MWrite    = '0;
        loadM     = 1'b0;
        kbd_valid = 1'b0;
        kbd_code  = '0;
        scr_ready = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        MAddr = 15'h6000;
        @(negedge clk);
        chk("rst_valid", 32'(scr_valid), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_ovf", 32'(scr_ovf), 32'd0);
        chk("rst_err", 32'(addr_err), 32'd0);
        chk("rst_kbd", 32'(MRead), 32'd0);
        cyc();

        // RAM write, read-during-write sees the old word
        wr(15'h0010, 16'h1111);
        wr(15'h0011, 16'h2222);
        MAddr  = 15'h0010;
        MWrite = 16'hBEEF;
        loadM  = 1'b1;
        @(negedge clk);
        chk("ram_rdw_old", 32'(MRead), 32'h1111);
        cyc();
        loadM = 1'b0;
        rd_chk("ram_new", 15'h0010, 16'hBEEF);
        rd_chk("ram_neighbour", 15'h0011, 16'h2222);

        // Single screen write and handoff
        exp_q.push_back({13'h0005, 16'h00FF});
        wr(15'h4005, 16'h00FF);
        MAddr = 15'h4005;
        @(negedge clk);
        chk("scr1_valid", 32'(scr_valid), 32'd1);
        chk("scr1_addr", 32'(scr_addr), 32'h5);
        chk("scr1_data", 32'(scr_data), 32'h00FF);
        chk("scr1_level", 32'(fifo_level), 32'd1);
        chk("scr1_shadow", 32'(MRead), 32'h00FF);
        cyc();
        scr_ready = 1'b1;
        cyc();
        scr_ready = 1'b0;
        @(negedge clk);
        chk("scr1_level_after", 32'(fifo_level), 32'd0);
        chk("scr1_valid_after", 32'(scr_valid), 32'd0);
        cyc();

        // Fill to 8, push while full with a pop, then drop a write
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back({13'(i), 16'(i + 1)});
            wr(15'h4000 + 15'(i), 16'(i + 1));
        end
        @(negedge clk);
        chk("full_level", 32'(fifo_level), 32'd8);
        chk("full_ovf", 32'(scr_ovf), 32'd0);
        cyc();
        MAddr     = 15'h4009;
        MWrite    = 16'h000A;
        loadM     = 1'b1;
        scr_ready = 1'b1;
        exp_q.push_back({13'h0009, 16'h000A});
        cyc();
        loadM     = 1'b0;
        scr_ready = 1'b0;
        @(negedge clk);
        chk("fullpop_level", 32'(fifo_level), 32'd8);
        chk("fullpop_ovf", 32'(scr_ovf), 32'd0);
        cyc();
        wr(15'h4008, 16'h0009);
        @(negedge clk);
        chk("ovf_level", 32'(fifo_level), 32'd8);
        chk("ovf_flag", 32'(scr_ovf), 32'd1);
        cyc();
        rd_chk("ovf_shadow", 15'h4008, 16'h0009);
        scr_ready = 1'b1;
        repeat (8) cyc();
        scr_ready = 1'b0;
        @(negedge clk);
        chk("drain_level", 32'(fifo_level), 32'd0);
        chk("drain_valid", 32'(scr_valid), 32'd0);
        chk("drain_sb_empty", 32'(exp_q.size()), 32'd0);
        cyc();

        // Keyboard register
        MAddr     = 15'h6000;
        kbd_code  = 16'h0041;
        kbd_valid = 1'b1;
        @(negedge clk);
        chk("kbd_same_cycle", 32'(MRead), 32'd0);
        cyc();
        kbd_valid = 1'b0;
        rd_chk("kbd_41", 15'h6000, 16'h0041);
        kbd_code  = 16'h0000;
        kbd_valid = 1'b1;
        cyc();
        kbd_valid = 1'b0;
        rd_chk("kbd_release", 15'h6000, 16'h0000);
        kbd_code  = 16'h0041;
        kbd_valid = 1'b1;
        cyc();
        kbd_valid = 1'b0;

        // Write to read-only keyboard and unmapped read
        wr(15'h6000, 16'h1234);
        MAddr = 15'h6000;
        @(negedge clk);
        chk("kbd_ro", 32'(MRead), 32'h0041);
        chk("addr_err", 32'(addr_err), 32'd1);
        cyc();
        rd_chk("unmapped_rd", 15'h7000, 16'h0000);

        // Reset mid-operation
        wr(15'h0005, 16'h0777);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({13'h10 + 13'(i), 16'h10 + 16'(i)});
            wr(15'h4010 + 15'(i), 16'h10 + 16'(i));
        end
        @(negedge clk);
        chk("pre_rst_level", 32'(fifo_level), 32'd3);
        cyc();
        rst       = 1'b1;
        scr_ready = 1'b1;
        kbd_valid = 1'b1;
        kbd_code  = 16'h5555;
        MAddr     = 15'h0005;
        MWrite    = 16'hDEAD;
        loadM     = 1'b1;
        cyc();
        rst       = 1'b0;
        scr_ready = 1'b0;
        kbd_valid = 1'b0;
        loadM     = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("post_rst_level", 32'(fifo_level), 32'd0);
        chk("post_rst_valid", 32'(scr_valid), 32'd0);
        chk("post_rst_ovf", 32'(scr_ovf), 32'd0);
        chk("post_rst_err", 32'(addr_err), 32'd0);
        cyc();
        rd_chk("post_rst_kbd", 15'h6000, 16'h0000);
        rd_chk("post_rst_ram", 15'h0005, 16'h0777);
        chk("end_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hack_mem_io.md
Name: hack_mem_io

Overview:
- Data-memory and memory-mapped I/O stage directly downstream of the CPU core.
- Consumes the core's MAddr/MWrite/loadM and returns MRead combinationally, as the core's ALU uses it in the same cycle.
- Decodes the 15-bit address space into:
  - general RAM;
  - a screen shadow buffer, whose writes are also forwarded to an external display through a FIFO with a valid/ready handshake;
  - a keyboard register loaded by an external key source.

Parameters:
- FIFO_DEPTH, 8, screen-write FIFO entries; must be a power of 2, at least 2.
- FIFO_AW, 3, log2(FIFO_DEPTH).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous reset, active-high.
- MAddr  input  15  CPU data address.
- MWrite  input  16  CPU write data.
- loadM  input  1  CPU write enable.
- MRead  output  16  read data for MAddr, combinational.
- kbd_valid  input  1  key source presents a new code.
- kbd_code  input  16  key code; 0 means no key / release.
- scr_valid  output  1  FIFO head valid toward display.
- scr_addr  output  13  screen word address of FIFO head.
- scr_data  output  16  pixel word of FIFO head.
- scr_ready  input  1  display accepts head this cycle.
- fifo_level  output  FIFO_AW+1  current FIFO occupancy.
- scr_ovf  output  1  sticky: a screen write was dropped from the FIFO.
- addr_err  output  1  sticky: write to an unmapped or read-only address.

Behaviour:
- Clock and reset: single clock domain clk. Reset is synchronous and active-high on rst; the clock and reset ports are named clk and rst.
- Address decode:
  - MAddr[14]==0: RAM, 16384x16, index MAddr[13:0].
  - MAddr[14:13]==2'b10: screen, 8192x16, index MAddr[12:0].
  - MAddr==15'h6000: keyboard register, read-only.
  - 15'h6001..15'h7FFF: unmapped; reads return 16'h0000.
- Reads: zero latency; MRead is a pure function of MAddr and current storage contents.
  - Read-during-write at the same address returns the old value in that cycle and the new value from the next cycle.
- RAM writes: when loadM=1 and the address decodes to RAM, storage is updated at posedge.
- Screen writes: when loadM=1 and the address decodes to screen:
  - the shadow buffer is always updated;
  - {MAddr[12:0], MWrite} is pushed to the FIFO.
- FIFO push acceptance:
  - A push is accepted if level<FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the entry is dropped, scr_ovf is set, and the shadow buffer is still updated.
- FIFO pop: occurs when scr_valid && scr_ready.
- FIFO outputs:
  - scr_valid = (level!=0).
  - scr_addr and scr_data reflect the head entry and are held stable while scr_valid && !scr_ready.
  - Entries leave in write order.
- Simultaneous push and pop:
  - level is unchanged.
  - When empty, push only: level becomes 1 and scr_valid rises the next cycle; there is no same-cycle bypass.
- Pointers wrap modulo FIFO_DEPTH; fifo_level ranges 0..FIFO_DEPTH.
- Keyboard register: on kbd_valid=1 it loads kbd_code at posedge; otherwise it holds. There is no ready signal; the source may assert on any cycle.
- Writes to the keyboard or unmapped addresses: ignored, and addr_err is set.
- Sticky flags: scr_ovf and addr_err clear only on rst.
- Reset (rst=1 at posedge):
  - keyboard register becomes 0; FIFO pointers and level become 0; scr_valid=0; scr_ovf=0; addr_err=0.
  - RAM and shadow contents are not cleared and are retained across reset.
  - loadM, kbd_valid and scr_ready are ignored in a reset cycle.
  - A reset mid-drain discards all queued entries; any head presented in the reset cycle is not considered accepted.
- MRead after reset: keyboard reads return 0. RAM and screen reads return retained contents; these are X in simulation if never written.

Test Plan:
- RAM: write 16'hBEEF to 15'h0010. In the same cycle MRead shows the old value; the next cycle MRead=16'hBEEF. Reading 15'h0011 shows it is unaffected.
- Screen path:
  - With scr_ready=0, write 16'h00FF to 15'h4005. The next cycle scr_valid=1, scr_addr=13'h0005, scr_data=16'h00FF, fifo_level=1.
  - A read of 15'h4005 returns 16'h00FF.
  - Raise scr_ready for 1 cycle: level becomes 0 and scr_valid=0.
- Overflow:
  - With scr_ready=0, write 9 screen words, data 1..9, at 15'h4000..15'h4008. Then level=8 and scr_ovf=1; the shadow at 15'h4008 reads 9.
  - Draining yields data 1..8 in order.
  - Additional check: at level=8, perform a write with scr_ready=1 in the same cycle. The entry is accepted, level stays 8, and scr_ovf is not newly set.
- Keyboard: pulse kbd_valid with code 16'h0041. Reading 15'h6000 returns 16'h0041 from the next cycle. Pulse kbd_valid with code 0, then the read returns 0.
- Keyboard write and unmapped access:
  - A write of 16'h1234 to 15'h6000 leaves the register unchanged and sets addr_err.
  - A read of 15'h7000 returns 0.
- Reset mid-operation:
  - With 3 FIFO entries queued, RAM[5]=16'h0777 and keyboard=16'h0041, assert rst for 1 cycle.
  - Afterwards: fifo_level=0, scr_valid=0, scr_ovf=0, addr_err=0, a keyboard read returns 0, and RAM[5] still reads 16'h0777.
